// File: rtl/rgb_stream_packer.sv
// rgb_stream_packer
// Packs a 24-bit {b,g,r} pixel stream four-pixels-into-three-words onto a
// 32-bit AXI4-Stream video bus. Frame start maps to tuser and end of line to
// tlast. A line that does not end on a word boundary is closed with a
// tkeep-qualified flush word. A frame start that arrives mid-group is flagged
// with a sticky alignment error, and frame_done pulses once the last word of
// the last line has been taken by the sink.
module rgb_stream_packer #(
   parameter int DATA_W = 32,
   parameter int PIX_W  = 24
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [PIX_W-1:0]    in_data,
   input  logic                in_valid,
   input  logic                in_first,
   input  logic                in_last_x,
   input  logic                in_last_y,
   output logic                in_ready,
   output logic [DATA_W-1:0]   out_tdata,
   output logic [DATA_W/8-1:0] out_tkeep,
   output logic                out_tvalid,
   input  logic                out_tready,
   output logic                out_tuser,
   output logic                out_tlast,
   output logic                err_align,
   output logic                frame_done
);

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_t;

   state_t              state;
   state_t              state_next;

   logic [1:0]          ph;
   logic [1:0]          ph_next;
   logic [PIX_W-1:0]    res;
   logic [PIX_W-1:0]    res_next;
   logic                sf;
   logic                sf_next;
   logic [DATA_W/8-1:0] flush_keep;
   logic [DATA_W/8-1:0] flush_keep_next;
   logic                flush_eof;
   logic                flush_eof_next;
   logic                out_eof;

   logic                accept;
   logic [1:0]          eff_ph;
   logic                pend_sof;
   logic                misalign;
   logic                load;
   logic [DATA_W-1:0]   load_data;
   logic [DATA_W/8-1:0] load_keep;
   logic                load_user;
   logic                load_last;
   logic                load_eof;

   // A pixel may only be taken while running and the single output register
   // is free or being emptied this cycle.
   assign in_ready = !reset && (state == RUN) && (!out_tvalid || out_tready);

   // Next-state and word-building logic: decides what (if anything) is loaded
   // into the output register and how the phase, residual and flags advance.
   always_comb begin
      state_next      = state;
      ph_next         = ph;
      res_next        = res;
      sf_next         = sf;
      flush_keep_next = flush_keep;
      flush_eof_next  = flush_eof;
      load            = 1'b0;
      load_data       = '0;
      load_keep       = '0;
      load_user       = 1'b0;
      load_last       = 1'b0;
      load_eof        = 1'b0;
      misalign        = 1'b0;
      accept          = in_valid && in_ready;
      eff_ph          = in_first ? 2'd0 : ph;
      pend_sof        = sf || in_first;

      case (state)
         RUN: begin
            if (accept) begin
               misalign  = in_first && (ph != 2'd0);
               ph_next   = in_last_x ? 2'd0 : eff_ph + 2'd1;
               load_user = pend_sof;
               case (eff_ph)
                  2'd0: begin
                     res_next = in_data;
                     if (in_last_x) begin
                        load      = 1'b1;
                        load_data = {8'h00, in_data};
                        load_keep = 4'b0111;
                        load_last = 1'b1;
                        load_eof  = in_last_y;
                     end
                  end
                  2'd1: begin
                     load      = 1'b1;
                     load_data = {in_data[7:0], res};
                     load_keep = 4'b1111;
                     res_next  = {8'h00, in_data[23:8]};
                     if (in_last_x) begin
                        state_next      = FLUSH;
                        flush_keep_next = 4'b0011;
                        flush_eof_next  = in_last_y;
                     end
                  end
                  2'd2: begin
                     load      = 1'b1;
                     load_data = {in_data[15:0], res[15:0]};
                     load_keep = 4'b1111;
                     res_next  = {16'h0000, in_data[23:16]};
                     if (in_last_x) begin
                        state_next      = FLUSH;
                        flush_keep_next = 4'b0001;
                        flush_eof_next  = in_last_y;
                     end
                  end
                  2'd3: begin
                     load      = 1'b1;
                     load_data = {in_data, res[7:0]};
                     load_keep = 4'b1111;
                     load_last = in_last_x;
                     load_eof  = in_last_x && in_last_y;
                  end
               endcase
               sf_next = load ? 1'b0 : pend_sof;
            end
         end
         FLUSH: begin
            if (!out_tvalid || out_tready) begin
               load       = 1'b1;
               load_data  = {8'h00, res};
               load_keep  = flush_keep;
               load_user  = sf;
               load_last  = 1'b1;
               load_eof   = flush_eof;
               sf_next    = 1'b0;
               state_next = RUN;
            end
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   // Packing context: phase, residual bytes, pending frame start and the
   // shape of a queued flush word.
   always_ff @(posedge clk) begin
      if (reset) begin
         ph         <= 2'd0;
         res        <= '0;
         sf         <= 1'b0;
         flush_keep <= '0;
         flush_eof  <= 1'b0;
      end else begin
         ph         <= ph_next;
         res        <= res_next;
         sf         <= sf_next;
         flush_keep <= flush_keep_next;
         flush_eof  <= flush_eof_next;
      end
   end

   // Output register: loads a new word when one is built, otherwise drops
   // valid once the sink has taken the current word, and holds under stall.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_tvalid <= 1'b0;
         out_tdata  <= '0;
         out_tkeep  <= '0;
         out_tuser  <= 1'b0;
         out_tlast  <= 1'b0;
         out_eof    <= 1'b0;
      end else if (load) begin
         out_tvalid <= 1'b1;
         out_tdata  <= load_data;
         out_tkeep  <= load_keep;
         out_tuser  <= load_user;
         out_tlast  <= load_last;
         out_eof    <= load_eof;
      end else if (out_tready) begin
         out_tvalid <= 1'b0;
      end
   end

   // Status: sticky misalignment flag and the end-of-frame pulse raised the
   // cycle after the final word of the last line is handed over.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_align  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         if (misalign) begin
            err_align <= 1'b1;
         end
         frame_done <= out_tvalid && out_tready && out_tlast && out_eof;
      end
   end

endmodule

// File: tb/tb_rgb_stream_packer.sv
// tb_rgb_stream_packer
// Directed vector table for the packing patterns, flush shapes and alignment
// error, a hand-written reset-under-stall sequence, then randomized frames
// with random sink back-pressure checked against a byte-queue model.
module tb_rgb_stream_packer;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        user;
      logic        last;
      logic        eof;
   } word_t;

   typedef struct {
      logic        valid;
      logic [23:0] pix;
      logic [2:0]  flags;
      logic        exp_tvalid;
      logic [31:0] exp_data;
      logic [3:0]  exp_keep;
      logic [1:0]  exp_ul;
      logic        exp_ready;
      logic        exp_err;
      logic        exp_fd;
   } vec_t;

   localparam int NV = 23;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [23:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_first = 1'b0;
   logic        in_last_x = 1'b0;
   logic        in_last_y = 1'b0;
   logic        in_ready;
   logic [31:0] out_tdata;
   logic [3:0]  out_tkeep;
   logic        out_tvalid;
   logic        out_tready = 1'b1;
   logic        out_tuser;
   logic        out_tlast;
   logic        err_align;
   logic        frame_done;

   int          tready_mode = 0;
   int          n_checks = 0;
   int          n_fails = 0;
   int          n_user = 0;
   int          n_last = 0;
   int          n_fd = 0;
   logic        mon_run = 1'b0;
   logic        sof_pending = 1'b0;
   logic [7:0]  byte_q[$];
   word_t       exp_q[$];
   vec_t        vecs[NV];

   rgb_stream_packer dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_first   (in_first),
      .in_last_x  (in_last_x),
      .in_last_y  (in_last_y),
      .in_ready   (in_ready),
      .out_tdata  (out_tdata),
      .out_tkeep  (out_tkeep),
      .out_tvalid (out_tvalid),
      .out_tready (out_tready),
      .out_tuser  (out_tuser),
      .out_tlast  (out_tlast),
      .err_align  (err_align),
      .frame_done (frame_done)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Sink back-pressure: always ready, never ready, or random per cycle.
   always @(posedge clk) begin
      #2;
      case (tready_mode)
         0:       out_tready = 1'b1;
         1:       out_tready = 1'b0;
         default: out_tready = ($urandom_range(0, 3) != 0);
      endcase
   end

   function automatic logic [41:0] snap();
      return {out_tvalid, out_tdata, out_tkeep, out_tuser, out_tlast,
              in_ready, err_align, frame_done};
   endfunction

   function automatic vec_t mk(input logic v, input logic [23:0] p,
                               input logic [2:0] fl, input logic ev,
                               input logic [31:0] d, input logic [3:0] k,
                               input logic [1:0] ul, input logic rdy,
                               input logic er, input logic fd);
      vec_t r;
      r.valid      = v;
      r.pix        = p;
      r.flags      = fl;
      r.exp_tvalid = ev;
      r.exp_data   = d;
      r.exp_keep   = k;
      r.exp_ul     = ul;
      r.exp_ready  = rdy;
      r.exp_err    = er;
      r.exp_fd     = fd;
      return r;
   endfunction

   task automatic check_output(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(input logic v, input logic [23:0] p,
                                 input logic [2:0] fl);
      in_valid  = v;
      in_data   = p;
      in_first  = fl[2];
      in_last_x = fl[1];
      in_last_y = fl[0];
   endtask

   // Reference model: pixels become r,g,b bytes in a queue; every four bytes
   // form a word, and a line end closes any leftover bytes into a partial word.
   task automatic model_pixel(input logic [23:0] pix, input logic fst,
                              input logic lx, input logic ly);
      word_t w;
      int    n;
      if (fst) begin
         byte_q.delete();
         sof_pending = 1'b1;
      end
      byte_q.push_back(pix[7:0]);
      byte_q.push_back(pix[15:8]);
      byte_q.push_back(pix[23:16]);
      while (byte_q.size() >= 4) begin
         w.data = {byte_q[3], byte_q[2], byte_q[1], byte_q[0]};
         repeat (4) void'(byte_q.pop_front());
         w.keep = 4'hF;
         w.user = sof_pending;
         w.last = lx && (byte_q.size() == 0);
         w.eof  = w.last && ly;
         sof_pending = 1'b0;
         exp_q.push_back(w);
      end
      if (lx && byte_q.size() != 0) begin
         w.data = '0;
         w.keep = '0;
         n = byte_q.size();
         for (int i = 0; i < n; i++) begin
            w.data[8*i +: 8] = byte_q[i];
            w.keep[i]        = 1'b1;
         end
         w.user = sof_pending;
         w.last = 1'b1;
         w.eof  = ly;
         sof_pending = 1'b0;
         exp_q.push_back(w);
         byte_q.delete();
      end
   endtask

   task automatic send_pixel(input logic [23:0] pix, input logic fst,
                             input logic lx, input logic ly);
      int waited = 0;
      apply_stimulus(1'b1, pix, {fst, lx, ly});
      @(negedge clk);
      while (!in_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         n_checks++;
         n_fails++;
         $display("[TB] FAIL in_ready_timeout: got 0 after %0d cycles, expected 1", waited);
      end else begin
         model_pixel(pix, fst, lx, ly);
      end
      @(posedge clk);
      #1;
      apply_stimulus(1'b0, 24'h0, 3'b000);
   endtask

   task automatic monitor_loop();
      word_t       exp_w;
      logic [37:0] held = '0;
      logic        stalled = 1'b0;
      logic        fd_exp = 1'b0;
      forever begin
         @(negedge clk);
         if (mon_run) begin
            check_output("frame_done", {63'h0, frame_done}, {63'h0, fd_exp});
            if (frame_done) n_fd++;
            fd_exp = 1'b0;
            if (stalled) begin
               check_output("stall_hold",
                            {26'h0, out_tvalid, out_tdata, out_tkeep, out_tuser, out_tlast},
                            {26'h0, 1'b1, held});
            end
            stalled = out_tvalid && !out_tready;
            held    = {out_tdata, out_tkeep, out_tuser, out_tlast};
            if (out_tvalid && out_tready) begin
               if (out_tuser) n_user++;
               if (out_tlast) n_last++;
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fails++;
                  $display("[TB] FAIL extra_word: got %h keep %h, expected no word",
                           out_tdata, out_tkeep);
               end else begin
                  exp_w = exp_q.pop_front();
                  check_output("word",
                               {26'h0, out_tdata, out_tkeep, out_tuser, out_tlast},
                               {26'h0, exp_w.data, exp_w.keep, exp_w.user, exp_w.last});
                  fd_exp = exp_w.eof;
               end
            end
         end
      end
   endtask

   initial begin
      logic [41:0] act;
      logic [41:0] exp;
      int          w;
      int          h;
      int          lines = 0;
      int          frames = 4;
      int          k;

      vecs[0]  = mk(1, 24'h112233, 3'b100, 0, 32'h0,        4'h0, 2'b00, 1, 0, 0);
      vecs[1]  = mk(1, 24'h445566, 3'b000, 1, 32'h66112233, 4'hF, 2'b10, 1, 0, 0);
      vecs[2]  = mk(1, 24'h778899, 3'b000, 1, 32'h88994455, 4'hF, 2'b00, 1, 0, 0);
      vecs[3]  = mk(1, 24'hAABBCC, 3'b011, 1, 32'hAABBCC77, 4'hF, 2'b01, 1, 0, 0);
      vecs[4]  = mk(0, 24'h000000, 3'b000, 0, 32'h0,        4'h0, 2'b00, 1, 0, 1);
      vecs[5]  = mk(1, 24'h010203, 3'b000, 0, 32'h0,        4'h0, 2'b00, 1, 0, 0);
      vecs[6]  = mk(1, 24'h040506, 3'b000, 1, 32'h06010203, 4'hF, 2'b00, 1, 0, 0);
      vecs[7]  = mk(1, 24'h070809, 3'b000, 1, 32'h08090405, 4'hF, 2'b00, 1, 0, 0);
      vecs[8]  = mk(1, 24'h0A0B0C, 3'b000, 1, 32'h0A0B0C07, 4'hF, 2'b00, 1, 0, 0);
      vecs[9]  = mk(1, 24'h0D0E0F, 3'b000, 0, 32'h0,        4'h0, 2'b00, 1, 0, 0);
      vecs[10] = mk(1, 24'h101112, 3'b010, 1, 32'h120D0E0F, 4'hF, 2'b00, 0, 0, 0);
      vecs[11] = mk(0, 24'h000000, 3'b000, 1, 32'h00001011, 4'h3, 2'b01, 1, 0, 0);
      vecs[12] = mk(1, 24'hC0FFEE, 3'b110, 1, 32'h00C0FFEE, 4'h7, 2'b11, 1, 0, 0);
      vecs[13] = mk(1, 24'h030201, 3'b000, 0, 32'h0,        4'h0, 2'b00, 1, 0, 0);
      vecs[14] = mk(1, 24'h060504, 3'b000, 1, 32'h04030201, 4'hF, 2'b00, 1, 0, 0);
      vecs[15] = mk(1, 24'h090807, 3'b010, 1, 32'h08070605, 4'hF, 2'b00, 0, 0, 0);
      vecs[16] = mk(0, 24'h000000, 3'b000, 1, 32'h00000009, 4'h1, 2'b01, 1, 0, 0);
      vecs[17] = mk(1, 24'h111111, 3'b000, 0, 32'h0,        4'h0, 2'b00, 1, 0, 0);
      vecs[18] = mk(1, 24'h222222, 3'b000, 1, 32'h22111111, 4'hF, 2'b00, 1, 0, 0);
      vecs[19] = mk(1, 24'h333333, 3'b100, 0, 32'h0,        4'h0, 2'b00, 1, 1, 0);
      vecs[20] = mk(1, 24'h444444, 3'b000, 1, 32'h44333333, 4'hF, 2'b10, 1, 1, 0);
      vecs[21] = mk(1, 24'h555555, 3'b010, 1, 32'h55554444, 4'hF, 2'b00, 0, 1, 0);
      vecs[22] = mk(0, 24'h000000, 3'b000, 1, 32'h00000055, 4'h1, 2'b01, 1, 1, 0);

      fork
         monitor_loop();
      join_none

      // Reset values while reset is held.
      repeat (2) @(posedge clk);
      #1;
      check_output("reset_state", {22'h0, snap()}, 64'h0);
      reset = 1'b0;

      // Directed vector table, sink always ready.
      for (int i = 0; i < NV; i++) begin
         apply_stimulus(vecs[i].valid, vecs[i].pix, vecs[i].flags);
         @(posedge clk);
         #1;
         act = snap();
         if (!vecs[i].exp_tvalid) act[40:3] = '0;
         exp = {vecs[i].exp_tvalid, vecs[i].exp_data, vecs[i].exp_keep,
                vecs[i].exp_ul, vecs[i].exp_ready, vecs[i].exp_err, vecs[i].exp_fd};
         check_output($sformatf("vec%0d", i), {22'h0, act}, {22'h0, exp});
      end

      // Reset while a word is stalled at phase 2.
      apply_stimulus(1'b0, 24'h0, 3'b000);
      @(posedge clk);
      #1;
      tready_mode = 1;
      apply_stimulus(1'b1, 24'hA1A2A3, 3'b000);
      @(posedge clk);
      #1;
      apply_stimulus(1'b1, 24'hB1B2B3, 3'b000);
      @(posedge clk);
      #1;
      apply_stimulus(1'b0, 24'h0, 3'b000);
      check_output("stall_word", {22'h0, snap()},
                   {22'h0, 1'b1, 32'hB3A1A2A3, 4'hF, 2'b00, 1'b0, 1'b1, 1'b0});
      @(posedge clk);
      #1;
      check_output("stall_word_held", {22'h0, snap()},
                   {22'h0, 1'b1, 32'hB3A1A2A3, 4'hF, 2'b00, 1'b0, 1'b1, 1'b0});
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_output("mid_reset", {22'h0, snap()}, 64'h0);
      reset = 1'b0;
      tready_mode = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check_output("no_flush_after_reset", {63'h0, out_tvalid}, 64'h0);
      end
      apply_stimulus(1'b1, 24'h0C0B0A, 3'b010);
      @(posedge clk);
      #1;
      apply_stimulus(1'b0, 24'h0, 3'b000);
      check_output("phase0_after_reset", {22'h0, snap()},
                   {22'h0, 1'b1, 32'h000C0B0A, 4'h7, 2'b01, 1'b1, 1'b0, 1'b0});
      repeat (2) @(posedge clk);
      #1;

      // Randomized frames with random back-pressure.
      mon_run     = 1'b1;
      tready_mode = 2;
      for (int f = 0; f < frames; f++) begin
         w = (f == 0) ? 16 : $urandom_range(1, 13);
         h = (f == 0) ? 4 : $urandom_range(1, 4);
         lines += h;
         for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk);
                  #1;
               end
               send_pixel(24'($urandom), (x == 0) && (y == 0), x == w - 1, y == h - 1);
            end
         end
      end

      k = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || out_tvalid) && k < 500) begin
         @(negedge clk);
         k++;
      end
      if (k >= 500) begin
         n_checks++;
         n_fails++;
         $display("[TB] FAIL drain_timeout: got %0d words pending, expected 0", exp_q.size());
      end
      repeat (2) @(negedge clk);
      mon_run = 1'b0;

      check_output("tuser_count", 64'(n_user), 64'(frames));
      check_output("tlast_count", 64'(n_last), 64'(lines));
      check_output("frame_done_count", 64'(n_fd), 64'(frames));
      check_output("err_align_clean", {63'h0, err_align}, 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
